hazard_scoreboard: RTL and testbench

Parametrised next-generation pipeline hazard unit for the 5-stage MIPS core. It adds a per-register latency scoreboard that generates RAW stalls in D for long-latency producers (load, mul/div). It generalises forwarding to FWD_STAGES ordered bypass sources. Flushes that arrive while the D-cache is stalled are held and applied later, not dropped.

---
 rtl/hazard_scoreboard_if.sv | 54 +++++
 rtl/hazard_scoreboard.sv | 122 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - pipeline-to-hazard-unit signal bundle
// master = pipeline side driving requests, slave = hazard unit driving controls.
interface hazard_scoreboard_if #(
    parameter int REG_AW     = 5,
    parameter int LAT_W      = 4,
    parameter int FWD_STAGES = 2,
    parameter int FWD_SEL_W  = 2
);
    logic                         i_cache_stall;
    logic                         d_cache_stall;
    logic                         alu_stallE;
    logic                         flush_jump_conflictE;
    logic                         flush_pred_failedM;
    logic                         flush_exceptionM;
    logic [REG_AW-1:0]            rsD;
    logic [REG_AW-1:0]            rtD;
    logic                         issue_wrD;
    logic [REG_AW-1:0]            issue_destD;
    logic [LAT_W-1:0]             issue_latD;
    logic [REG_AW-1:0]            rsE;
    logic [REG_AW-1:0]            rtE;
    logic [FWD_STAGES-1:0]        fwd_wr;
    logic [FWD_STAGES*REG_AW-1:0] fwd_reg;
    logic                         stallF, stallD, stallE, stallM, stallW;
    logic                         flushF, flushD, flushE, flushM, flushW;
    logic                         longest_stall;
    logic                         raw_stallD;
    logic [FWD_SEL_W-1:0]         forward_1E;
    logic [FWD_SEL_W-1:0]         forward_2E;
    logic [31:0]                  perf_raw_cnt;
    logic [31:0]                  perf_cache_cnt;

    modport master (
        output i_cache_stall, d_cache_stall, alu_stallE,
        output flush_jump_conflictE, flush_pred_failedM, flush_exceptionM,
        output rsD, rtD, issue_wrD, issue_destD, issue_latD,
        output rsE, rtE, fwd_wr, fwd_reg,
        input  stallF, stallD, stallE, stallM, stallW,
        input  flushF, flushD, flushE, flushM, flushW,
        input  longest_stall, raw_stallD, forward_1E, forward_2E,
        input  perf_raw_cnt, perf_cache_cnt
    );

    modport slave (
        input  i_cache_stall, d_cache_stall, alu_stallE,
        input  flush_jump_conflictE, flush_pred_failedM, flush_exceptionM,
        input  rsD, rtD, issue_wrD, issue_destD, issue_latD,
        input  rsE, rtE, fwd_wr, fwd_reg,
        output stallF, stallD, stallE, stallM, stallW,
        output flushF, flushD, flushE, flushM, flushW,
        output longest_stall, raw_stallD, forward_1E, forward_2E,
        output perf_raw_cnt, perf_cache_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - latency scoreboard hazard unit with deferred flushes and N-source bypass
// Define HAZARD_PERF_EN to build the saturating RAW/cache stall performance counters.
module hazard_scoreboard #(
    parameter int REG_NUM    = 32,
    parameter int REG_AW     = 5,
    parameter int LAT_W      = 4,
    parameter int FWD_STAGES = 2,
    parameter int FWD_SEL_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    hazard_scoreboard_if.slave hz
);
    logic [LAT_W-1:0] cnt      [REG_NUM];
    logic [LAT_W-1:0] cnt_next [REG_NUM];
    logic [LAT_W-1:0] dec_val;
    logic             pend_jump, pend_pred;
    logic             cache_stall, longest_stall, raw_stall;
    logic             stall_d, flush_d, issue, jf, pf;
    logic [FWD_SEL_W-1:0] fwd1, fwd2;

    assign cache_stall   = hz.i_cache_stall | hz.d_cache_stall;
    assign longest_stall = cache_stall | hz.alu_stallE;
    assign raw_stall     = ((hz.rsD != '0) && (cnt[hz.rsD] > LAT_W'(1))) |
                           ((hz.rtD != '0) && (cnt[hz.rtD] > LAT_W'(1)));
    assign jf      = (hz.flush_jump_conflictE | pend_jump) & ~hz.d_cache_stall;
    assign pf      = hz.flush_pred_failedM | pend_pred;
    assign stall_d = longest_stall | raw_stall;
    assign flush_d = hz.flush_exceptionM | hz.flush_pred_failedM | jf;
    assign issue   = hz.issue_wrD & (hz.issue_destD != '0) & ~stall_d & ~flush_d;

    assign hz.stallF = ~hz.flush_exceptionM & stall_d;
    assign hz.stallD = stall_d;
    assign hz.stallE = longest_stall;
    assign hz.stallM = cache_stall;
    assign hz.stallW = cache_stall;
    assign hz.flushF = 1'b0;
    assign hz.flushD = flush_d;
    // raw_stall & ~longest_stall drops a bubble into E while D waits
    assign hz.flushE = hz.flush_exceptionM | (pf & ~longest_stall) | jf |
                       (raw_stall & ~longest_stall);
    assign hz.flushM = hz.flush_exceptionM;
    assign hz.flushW = hz.flush_exceptionM;
    assign hz.longest_stall = longest_stall;
    assign hz.raw_stallD    = raw_stall;
    assign hz.forward_1E    = fwd1;
    assign hz.forward_2E    = fwd2;

    always_comb begin
        dec_val = '0;
        for (int r = 0; r < REG_NUM; r++) begin
            dec_val = ((cnt[r] != '0) && !cache_stall) ? cnt[r] - LAT_W'(1) : cnt[r];
            cnt_next[r] = dec_val;
            if (issue && (hz.issue_destD == REG_AW'(r)) && (hz.issue_latD > dec_val))
                cnt_next[r] = hz.issue_latD;
            if (hz.flush_exceptionM)
                cnt_next[r] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < REG_NUM; r++) cnt[r] <= cnt_next[r];
        end
    end

    // Deferred flushes: remembered across the stall, fired on the first free cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_jump <= 1'b0;
            pend_pred <= 1'b0;
        end else if (hz.flush_exceptionM) begin
            pend_jump <= 1'b0;
            pend_pred <= 1'b0;
        end else begin
            if (!hz.d_cache_stall)
                pend_jump <= 1'b0;
            else if (hz.flush_jump_conflictE)
                pend_jump <= 1'b1;
            if (!longest_stall)
                pend_pred <= 1'b0;
            else if (hz.flush_pred_failedM)
                pend_pred <= 1'b1;
        end
    end

    // Scan oldest to youngest so the youngest matching source wins
    always_comb begin
        fwd1 = '0;
        fwd2 = '0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (hz.fwd_wr[k-1] && (hz.fwd_reg[k*REG_AW-1 -: REG_AW] == hz.rsE) && (hz.rsE != '0))
                fwd1 = FWD_SEL_W'(k);
            if (hz.fwd_wr[k-1] && (hz.fwd_reg[k*REG_AW-1 -: REG_AW] == hz.rtE) && (hz.rtE != '0))
                fwd2 = FWD_SEL_W'(k);
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_raw, perf_cache;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_raw   <= '0;
            perf_cache <= '0;
        end else begin
            if (raw_stall && !longest_stall && (perf_raw != 32'hFFFF_FFFF))
                perf_raw <= perf_raw + 32'd1;
            if (cache_stall && (perf_cache != 32'hFFFF_FFFF))
                perf_cache <= perf_cache + 32'd1;
        end
    end

    assign hz.perf_raw_cnt   = perf_raw;
    assign hz.perf_cache_cnt = perf_cache;
`else
    assign hz.perf_raw_cnt   = '0;
    assign hz.perf_cache_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench: driver pushes model predictions, negedge monitor compares
// Honours HAZARD_PERF_EN the same way the design does.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if hz ();
    hazard_scoreboard dut (.clk(clk), .rst(rst), .hz(hz));

    typedef struct {
        bit       ic, dc, alu, fj, fp, fe, wr;
        bit [4:0] rsD, rtD, dest, rsE, rtE;
        bit [3:0] lat;
        bit [1:0] fwr;
        bit [9:0] freg;
    } stim_t;

    typedef struct {
        bit          stallF, stallD, stallE, stallM, stallW;
        bit          flushF, flushD, flushE, flushM, flushW;
        bit          ls, raw;
        bit [1:0]    f1, f2;
        logic [31:0] praw, pcache;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          m_cnt[32];
    bit          m_pj, m_pp;
    logic [31:0] m_praw, m_pcache;
    stim_t       cur;
    exp_t        cur_e;
    int          ic_b = 0, dc_b = 0, alu_b = 0;

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic bit [1:0] fwd_of(bit [4:0] r, bit [1:0] wr, bit [9:0] regs);
        bit [4:0] src [2];
        src[0] = regs[4:0];
        src[1] = regs[9:5];
        if (r == 0) return 2'd0;
        for (int k = 1; k <= 2; k++)
            if (wr[k-1] && src[k-1] == r) return 2'(k);
        return 2'd0;
    endfunction

    function automatic exp_t predict(stim_t s);
        exp_t e;
        bit cs, ls, raw, jf, pf;
        cs  = s.ic | s.dc;
        ls  = cs | s.alu;
        raw = (s.rsD != 0 && m_cnt[s.rsD] > 1) || (s.rtD != 0 && m_cnt[s.rtD] > 1);
        jf  = (s.fj | m_pj) & ~s.dc;
        pf  = s.fp | m_pp;
        e.stallF = ~s.fe & (ls | raw);
        e.stallD = ls | raw;
        e.stallE = ls;
        e.stallM = cs;
        e.stallW = cs;
        e.flushF = 1'b0;
        e.flushD = s.fe | s.fp | jf;
        e.flushE = s.fe | (pf & ~ls) | jf | (raw & ~ls);
        e.flushM = s.fe;
        e.flushW = s.fe;
        e.ls     = ls;
        e.raw    = raw;
        e.f1     = fwd_of(s.rsE, s.fwr, s.freg);
        e.f2     = fwd_of(s.rtE, s.fwr, s.freg);
`ifdef HAZARD_PERF_EN
        e.praw   = m_praw;
        e.pcache = m_pcache;
`else
        e.praw   = 32'd0;
        e.pcache = 32'd0;
`endif
        return e;
    endfunction

    task automatic model_reset();
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_pj = 0; m_pp = 0; m_praw = 0; m_pcache = 0;
    endtask

    // Advance the reference model across one clock edge using last cycle's stimulus
    task automatic model_step();
        bit cs, ls, issue;
        cs    = cur.ic | cur.dc;
        ls    = cs | cur.alu;
        issue = cur.wr && cur.dest != 0 && !cur_e.stallD && !cur_e.flushD;
        if (cur_e.raw && !ls && m_praw != 32'hFFFF_FFFF) m_praw++;
        if (cs && m_pcache != 32'hFFFF_FFFF) m_pcache++;
        if (cur.fe) begin
            foreach (m_cnt[r]) m_cnt[r] = 0;
            m_pj = 0;
            m_pp = 0;
        end else begin
            foreach (m_cnt[r]) if (m_cnt[r] > 0 && !cs) m_cnt[r]--;
            if (issue && cur.lat > m_cnt[cur.dest]) m_cnt[cur.dest] = cur.lat;
            if (!cur.dc) m_pj = 0; else if (cur.fj) m_pj = 1;
            if (!ls) m_pp = 0; else if (cur.fp) m_pp = 1;
        end
    endtask

    task automatic apply(stim_t s);
        hz.i_cache_stall        = s.ic;
        hz.d_cache_stall        = s.dc;
        hz.alu_stallE           = s.alu;
        hz.flush_jump_conflictE = s.fj;
        hz.flush_pred_failedM   = s.fp;
        hz.flush_exceptionM     = s.fe;
        hz.rsD                  = s.rsD;
        hz.rtD                  = s.rtD;
        hz.issue_wrD            = s.wr;
        hz.issue_destD          = s.dest;
        hz.issue_latD           = s.lat;
        hz.rsE                  = s.rsE;
        hz.rtE                  = s.rtE;
        hz.fwd_wr               = s.fwr;
        hz.fwd_reg              = s.freg;
    endtask

    task automatic drive_cycle(stim_t s, bit r);
        @(posedge clk);
        if (!rst) model_step();
        #1;
        rst = r;
        if (r) model_reset();
        apply(s);
        cur   = s;
        cur_e = predict(s);
        q.push_back(cur_e);
    endtask

    function automatic bit [3:0] rand_lat();
        case ($urandom % 3)
            0:       return 4'd1;
            1:       return 4'd2;
            default: return 4'($urandom_range(3, 15));
        endcase
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        if (ic_b == 0 && $urandom % 25 == 0) ic_b = $urandom_range(1, 4);
        if (dc_b == 0 && $urandom % 20 == 0) dc_b = $urandom_range(1, 5);
        if (alu_b == 0 && $urandom % 25 == 0) alu_b = $urandom_range(1, 3);
        s.ic  = (ic_b > 0);
        s.dc  = (dc_b > 0);
        s.alu = (alu_b > 0);
        if (ic_b > 0) ic_b--;
        if (dc_b > 0) dc_b--;
        if (alu_b > 0) alu_b--;
        s.fj   = ($urandom % 12 == 0);
        s.fp   = ($urandom % 12 == 0);
        s.fe   = ($urandom % 40 == 0);
        s.wr   = ($urandom % 10 < 7);
        s.rsD  = 5'($urandom % 6);
        s.rtD  = 5'($urandom % 6);
        s.dest = 5'($urandom % 6);
        s.lat  = rand_lat();
        s.rsE  = 5'($urandom % 6);
        s.rtE  = 5'($urandom % 6);
        s.fwr  = 2'($urandom);
        s.freg = {5'($urandom % 6), 5'($urandom % 6)};
        return s;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stallF", 32'(hz.stallF), 32'(e.stallF));
                chk("stallD", 32'(hz.stallD), 32'(e.stallD));
                chk("stallE", 32'(hz.stallE), 32'(e.stallE));
                chk("stallM", 32'(hz.stallM), 32'(e.stallM));
                chk("stallW", 32'(hz.stallW), 32'(e.stallW));
                chk("flushF", 32'(hz.flushF), 32'(e.flushF));
                chk("flushD", 32'(hz.flushD), 32'(e.flushD));
                chk("flushE", 32'(hz.flushE), 32'(e.flushE));
                chk("flushM", 32'(hz.flushM), 32'(e.flushM));
                chk("flushW", 32'(hz.flushW), 32'(e.flushW));
                chk("longest_stall", 32'(hz.longest_stall), 32'(e.ls));
                chk("raw_stallD", 32'(hz.raw_stallD), 32'(e.raw));
                chk("forward_1E", 32'(hz.forward_1E), 32'(e.f1));
                chk("forward_2E", 32'(hz.forward_2E), 32'(e.f2));
                chk("perf_raw_cnt", hz.perf_raw_cnt, e.praw);
                chk("perf_cache_cnt", hz.perf_cache_cnt, e.pcache);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        stim_t s;
        model_reset();
        cur = idle_stim();
        apply(cur);
        cur_e = predict(cur);
        drive_cycle(idle_stim(), 1'b1);
        drive_cycle(idle_stim(), 1'b0);

        // load r8 lat 2, dependent consumer, then consumer in E picks source 2
        s = idle_stim(); s.wr = 1; s.dest = 8; s.lat = 2; drive_cycle(s, 0);
        s = idle_stim(); s.rsD = 8; drive_cycle(s, 0); drive_cycle(s, 0);
        s = idle_stim(); s.rsE = 8; s.fwr = 2'b10; s.freg = {5'd8, 5'd0}; drive_cycle(s, 0);

        // div r9 lat 6 with an I-cache stall in the middle of the wait
        s = idle_stim(); s.wr = 1; s.dest = 9; s.lat = 6; drive_cycle(s, 0);
        s = idle_stim(); s.rtD = 9;
        repeat (2) drive_cycle(s, 0);
        s.ic = 1; repeat (3) drive_cycle(s, 0);
        s.ic = 0; repeat (5) drive_cycle(s, 0);

        // jump conflict during a 4-cycle D-cache stall
        s = idle_stim(); s.dc = 1; s.fj = 1; drive_cycle(s, 0);
        s.fj = 0; repeat (3) drive_cycle(s, 0);
        repeat (2) drive_cycle(idle_stim(), 0);

        // exception clears a pending latency and unfreezes F despite ALU busy
        s = idle_stim(); s.wr = 1; s.dest = 5; s.lat = 4; drive_cycle(s, 0);
        s = idle_stim(); s.fe = 1; s.alu = 1; s.rsD = 5; drive_cycle(s, 0);
        s = idle_stim(); s.rsD = 5; drive_cycle(s, 0);

        // two sources match rsE, rtE zero never forwards
        s = idle_stim(); s.fwr = 2'b11; s.freg = {5'd7, 5'd7}; s.rsE = 7; s.rtE = 0;
        drive_cycle(s, 0);

        // ten cache-stall cycles
        s = idle_stim(); s.ic = 1; repeat (10) drive_cycle(s, 0);
        drive_cycle(idle_stim(), 0);

        // reset while a jump flush is pending
        s = idle_stim(); s.dc = 1; s.fj = 1; drive_cycle(s, 0);
        s.fj = 0; drive_cycle(s, 0);
        drive_cycle(idle_stim(), 1);
        repeat (2) drive_cycle(idle_stim(), 0);

        for (int i = 0; i < 1500; i++)
            drive_cycle(rand_stim(), ($urandom % 300 == 0));

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
